// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
// Holds the result-class codes used by the hazard unit, the default reset PC
// and the default field widths for the exception code and the Tnew counter.
package mips_pipe_pkg;

    localparam int unsigned DEF_RES_W  = 3;
    localparam int unsigned DEF_TNEW_W = 2;
    localparam int unsigned DEF_EXC_W  = 5;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

    // Result class of an instruction: where (and whether) its value is produced.
    typedef enum logic [DEF_RES_W-1:0] {
        RES_NW  = 3'd0,  // no register write
        RES_ALU = 3'd1,
        RES_DM  = 3'd2,
        RES_PC  = 3'd3,
        RES_MD  = 3'd4
    } res_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (D/E, E/M, M/W) for the five-stage MIPS CPU.
// Carries a payload plus the hazard tag (A3, Res, Tnew), the PC, BD bit and
// exception code. Supports stall (hold), flush (bubble) and Tnew ageing.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          hold / bubble control (flush wins)
//   in_*                  fields from the previous stage
//   out_*                 registered fields; out_tnew is already aged
//   out_valid             1 = real instruction, 0 = bubble
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned RES_W            = DEF_RES_W,
    parameter int unsigned TNEW_W           = DEF_TNEW_W,
    parameter int unsigned EXC_W            = DEF_EXC_W,
    parameter logic [31:0] RESET_PC         = DEF_RESET_PC,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RES_W-1:0]  in_res,
    input  logic [4:0]        in_a3,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    output logic [DATA_W-1:0] out_data,
    output logic [RES_W-1:0]  out_res,
    output logic [4:0]        out_a3,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [4:0]        a3_q, a3_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [31:0]       pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              valid_q, valid_d;

    logic              writes_reg;
    logic [TNEW_W-1:0] tnew_aged;

    // $0 is never a forwarding source, so its tag is cleared on load.
    assign writes_reg = (in_a3 != 5'd0);
    // Saturating decrement: a value already ready stays ready.
    assign tnew_aged  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

    always_comb begin
        data_d  = data_q;
        res_d   = res_q;
        a3_d    = a3_q;
        tnew_d  = tnew_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        valid_d = valid_q;

        if (flush) begin
            data_d  = '0;
            res_d   = '0;
            a3_d    = '0;
            tnew_d  = '0;
            exc_d   = '0;
            valid_d = 1'b0;
            // Keeping the PC/BD lets a bubble still report a sensible EPC.
            if (KEEP_PC_ON_FLUSH) begin
                pc_d = in_pc;
                bd_d = in_bd;
            end else begin
                pc_d = RESET_PC;
                bd_d = 1'b0;
            end
        end else if (!stall) begin
            data_d  = in_data;
            res_d   = writes_reg ? in_res : '0;
            a3_d    = in_a3;
            tnew_d  = writes_reg ? tnew_aged : '0;
            pc_d    = in_pc;
            bd_d    = in_bd;
            exc_d   = in_exc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            res_q   <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            pc_q    <= RESET_PC;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            res_q   <= res_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_res   = res_q;
    assign out_a3    = a3_q;
    assign out_tnew  = tnew_q;
    assign out_pc    = pc_q;
    assign out_bd    = bd_q;
    assign out_exc   = exc_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (PC kept / PC reset on flush) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_pipe_stage_reg;
    import mips_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] in_data;
    logic [2:0]  in_res;
    logic [4:0]  in_a3;
    logic [1:0]  in_tnew;
    logic [31:0] in_pc;
    logic        in_bd;
    logic [4:0]  in_exc;

    logic [31:0] d0_data, d1_data, d0_pc, d1_pc;
    logic [2:0]  d0_res, d1_res;
    logic [4:0]  d0_a3, d1_a3, d0_exc, d1_exc;
    logic [1:0]  d0_tnew, d1_tnew;
    logic        d0_bd, d1_bd, d0_valid, d1_valid;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b1)) u_keep (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_data(in_data), .in_res(in_res), .in_a3(in_a3), .in_tnew(in_tnew),
        .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .out_data(d0_data), .out_res(d0_res), .out_a3(d0_a3), .out_tnew(d0_tnew),
        .out_pc(d0_pc), .out_bd(d0_bd), .out_exc(d0_exc), .out_valid(d0_valid)
    );

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) u_nokeep (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_data(in_data), .in_res(in_res), .in_a3(in_a3), .in_tnew(in_tnew),
        .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
        .out_data(d1_data), .out_res(d1_res), .out_a3(d1_a3), .out_tnew(d1_tnew),
        .out_pc(d1_pc), .out_bd(d1_bd), .out_exc(d1_exc), .out_valid(d1_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] data;
        logic [2:0]  res;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } stage_t;

    stage_t m0, m1;
    bit     model_ok = 1'b0;

    function automatic stage_t model_next(stage_t cur, bit keep_pc);
        stage_t n = cur;
        int     t;
        if (reset) begin
            n = '{data: 0, res: 0, a3: 0, tnew: 0, pc: 32'h3000, bd: 0, exc: 0, valid: 0};
        end else if (flush) begin
            n = '{data: 0, res: 0, a3: 0, tnew: 0, pc: keep_pc ? in_pc : 32'h3000,
                  bd: keep_pc ? in_bd : 1'b0, exc: 0, valid: 0};
        end else if (!stall) begin
            t = int'(in_tnew) - 1;
            if (t < 0) t = 0;
            n.data  = in_data;
            n.pc    = in_pc;
            n.bd    = in_bd;
            n.exc   = in_exc;
            n.valid = 1'b1;
            n.a3    = in_a3;
            n.res   = (in_a3 == 0) ? 3'd0 : in_res;
            n.tnew  = (in_a3 == 0) ? 2'd0 : 2'(t);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = model_next(m0, 1'b1);
        m1 = model_next(m1, 1'b0);
        if (reset) model_ok = 1'b1;
    end

    // Compare process: every cycle once the model is defined.
    always @(negedge clk) begin
        if (model_ok) begin
            check("keep.data",  d0_data,  m0.data);
            check("keep.res",   d0_res,   m0.res);
            check("keep.a3",    d0_a3,    m0.a3);
            check("keep.tnew",  d0_tnew,  m0.tnew);
            check("keep.pc",    d0_pc,    m0.pc);
            check("keep.bd",    d0_bd,    m0.bd);
            check("keep.exc",   d0_exc,   m0.exc);
            check("keep.valid", d0_valid, m0.valid);
            check("nok.data",   d1_data,  m1.data);
            check("nok.res",    d1_res,   m1.res);
            check("nok.a3",     d1_a3,    m1.a3);
            check("nok.tnew",   d1_tnew,  m1.tnew);
            check("nok.pc",     d1_pc,    m1.pc);
            check("nok.bd",     d1_bd,    m1.bd);
            check("nok.exc",    d1_exc,   m1.exc);
            check("nok.valid",  d1_valid, m1.valid);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_data = $urandom;
        in_res  = 3'($urandom_range(0, 4));
        in_a3   = 5'($urandom);
        in_tnew = 2'($urandom);
        in_pc   = $urandom;
        in_bd   = 1'($urandom);
        in_exc  = 5'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        rand_inputs();
        #1;
        step();
        rand_inputs();
        step();
        check("rst.pc",    d0_pc,    32'h3000);
        check("rst.valid", d0_valid, 0);
        check("rst.data",  d0_data,  0);
        check("rst.a3",    d0_a3,    0);
        check("rst.tnew",  d0_tnew,  0);
        check("rst.bd",    d0_bd,    0);

        // Load and ageing
        reset = 1'b0;
        in_a3 = 5'd8; in_res = RES_DM; in_tnew = 2'd2;
        in_data = 32'hDEAD_BEEF; in_pc = 32'h3004; in_bd = 1'b0; in_exc = 5'd0;
        step();
        check("load.a3",    d0_a3,    8);
        check("load.res",   d0_res,   2);
        check("load.tnew",  d0_tnew,  1);
        check("load.data",  d0_data,  32'hDEAD_BEEF);
        check("load.pc",    d0_pc,    32'h3004);
        check("load.valid", d0_valid, 1);
        in_tnew = 2'd0;
        step();
        check("sat.tnew", d0_tnew, 0);
        in_tnew = 2'd3;
        step();
        check("max.tnew", d0_tnew, 2);

        // $0 suppression
        in_a3 = 5'd0; in_res = RES_ALU; in_tnew = 2'd1;
        step();
        check("zero.a3",    d0_a3,    0);
        check("zero.res",   d0_res,   0);
        check("zero.tnew",  d0_tnew,  0);
        check("zero.valid", d0_valid, 1);

        // Stall
        in_a3 = 5'd5; in_tnew = 2'd2; in_res = RES_ALU; in_data = 32'h5555_0000;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a3 = 5'(9 + i); in_tnew = 2'd3; in_data = 32'(i);
            step();
            check("stall.a3",   d0_a3,   5);
            check("stall.tnew", d0_tnew, 1);
            check("stall.data", d0_data, 32'h5555_0000);
        end
        stall = 1'b0;
        in_a3 = 5'd12; in_tnew = 2'd3; in_data = 32'h0000_1234;
        step();
        check("rel.a3",   d0_a3,   12);
        check("rel.tnew", d0_tnew, 2);
        check("rel.data", d0_data, 32'h0000_1234);

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        in_pc = 32'h3010; in_bd = 1'b1; in_exc = 5'd4; in_a3 = 5'd6;
        step();
        check("fl.valid",    d0_valid, 0);
        check("fl.a3",       d0_a3,    0);
        check("fl.exc",      d0_exc,   0);
        check("fl.pc",       d0_pc,    32'h3010);
        check("fl.bd",       d0_bd,    1);
        check("fl_nok.pc",   d1_pc,    32'h3000);
        check("fl_nok.bd",   d1_bd,    0);
        check("fl_nok.valid", d1_valid, 0);

        // Reset mid-stall
        flush = 1'b0; stall = 1'b0;
        in_a3 = 5'd7; in_tnew = 2'd1; in_exc = 5'd3;
        step();
        check("pre.a3",  d0_a3,  7);
        check("pre.exc", d0_exc, 3);
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("rs.a3",    d0_a3,    0);
        check("rs.pc",    d0_pc,    32'h3000);
        check("rs.valid", d0_valid, 0);
        check("rs.exc",   d0_exc,   0);
        reset = 1'b0; stall = 1'b0;

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS microsystem CPU, used for the D/E, E/M and M/W boundaries. Each instance carries a generic payload plus the hazard-tracking tag (destination register A3, result class Res, time-to-new-value Tnew), the PC, and exception state. It supports hold (stall), bubble insertion (flush), and automatic Tnew ageing, so the hazard unit reads ready-to-compare tags directly from every stage.

## Interface
Parameters:
- DATA_W, 32: payload width (ALU result, memory data, and so on); must be ≥1.
- RES_W, 3: result-class code width.
- TNEW_W, 2: Tnew counter width.
- EXC_W, 5: exception-code width.
- RESET_PC, 32'h0000_3000: PC value presented after reset.
- KEEP_PC_ON_FLUSH, 1: 1 means a bubble keeps the incoming PC and BD bit (for EPC); 0 means a bubble loads RESET_PC and BD=0.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: hold all registers.
- flush, input, 1: load a bubble instead of the input.
- in_data, input, DATA_W: payload from the previous stage.
- in_res, input, RES_W: result class.
- in_a3, input, 5: destination register.
- in_tnew, input, TNEW_W: Tnew as seen in the previous stage.
- in_pc, input, 32: instruction PC.
- in_bd, input, 1: instruction sits in a branch delay slot.
- in_exc, input, EXC_W: exception code; 0 means none.
- out_data, output, DATA_W: registered payload.
- out_res, output, RES_W: registered result class.
- out_a3, output, 5: registered destination register.
- out_tnew, output, TNEW_W: aged Tnew.
- out_pc, output, 32: registered PC.
- out_bd, output, 1: registered BD bit.
- out_exc, output, EXC_W: registered exception code.
- out_valid, output, 1: 1 means a real instruction; 0 means a bubble.

## Operation
- Update priority on each rising edge: reset, then flush, then stall, then load.
- Reset: every output is 0, except out_pc = RESET_PC. out_valid = 0.
- Flush (a bubble):
  - out_data, out_res, out_a3, out_tnew, out_exc and out_valid are all 0.
  - out_pc and out_bd follow KEEP_PC_ON_FLUSH.
  - Flush wins over a simultaneous stall.
- Stall: all outputs hold their values, including out_tnew. There is no ageing while stalled.
- Load: all fields are copied from the inputs, with these exceptions:
  - out_tnew = (in_tnew == 0) ? 0 : in_tnew − 1. This is a saturating decrement and never wraps to all-ones.
  - If in_a3 == 0, then out_a3 = 0, out_res = 0 and out_tnew = 0. Writes to $0 are never forwarded.
  - out_valid = 1.
- The block does no arithmetic on the payload. Width rules apply only to Tnew.

## Timing
- Latency is 1 cycle from input to output on a load.
- All outputs are registered. There is no combinational path from any input to any output.
- stall and flush are sampled on the same edge as the data.
- reset asserted during a stall still clears the register on that edge.
- Deasserting stall loads the input present on that edge. No input is lost or duplicated.
- out_tnew reaches 0 at the latest after TNEW_W-limited ageing: at most 2^TNEW_W−1 non-stalled loads.

## Structure
- A shared package `mips_pipe_pkg` holds:
  - the Res codes: RES_NW=0, RES_ALU=1, RES_DM=2, RES_PC=3, RES_MD=4;
  - the default RESET_PC;
  - EXC_W;
  - the Tnew width.
- Single module, no sub-module. The Tnew saturating decrement is written inline.

## Test plan
- Reset: hold reset for 2 cycles with random inputs. Then out_pc = 0x3000, every other output = 0, out_valid = 0.
- Load and ageing:
  - Stimulus: in_a3=8, in_res=RES_DM, in_tnew=2, in_data=0xDEADBEEF, in_pc=0x3004.
  - Expected one cycle later: out_a3=8, out_res=2, out_tnew=1, out_data=0xDEADBEEF, out_valid=1.
  - With in_tnew=0, expected out_tnew=0 (no wrap).
- $0 suppression: in_a3=0, in_res=RES_ALU, in_tnew=1. Expected out_a3=0, out_res=0, out_tnew=0, out_valid=1.
- Stall: load a3=5, tnew=2, then stall for 3 cycles while the inputs change. Outputs stay a3=5, tnew=1. On release, the current inputs appear one cycle later.
- Flush with stall, KEEP_PC_ON_FLUSH=1:
  - Stimulus: flush=1 and stall=1, with in_pc=0x3010, in_bd=1, in_exc=4.
  - Expected: out_valid=0, out_a3=0, out_exc=0, out_pc=0x3010, out_bd=1.
  - Rerun with KEEP_PC_ON_FLUSH=0: expected out_pc=0x3000, out_bd=0.
- Reset mid-stall: load a3=7, assert stall, then assert reset while stall is still high. On the next edge all outputs return to their reset values.
